// File: rtl/sump_cmd_assembler.sv
// sump_cmd_assembler: frames received UART bytes into 40-bit SUMP commands {opdata, opcode}.
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   rx_valid    in   single-cycle strobe, rx_data holds a new byte
//   rx_data     in   received byte
//   cmd         out  assembled command: [7:0] opcode, [39:8] data (first data byte in [15:8])
//   execute     out  one-cycle strobe, cmd holds a new complete command
//   busy        out  high while a long command is partially received
//   timeout_err out  one-cycle strobe, a partial long command was discarded
module sump_cmd_assembler #(
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [39:0] cmd,
    output logic        execute,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic {IDLE, DATA} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [7:0]        op_q, op_d;
    logic [31:0]       data_q, data_d;
    logic [39:0]       cmd_d;
    logic              exec_d, terr_d;
    logic              expired;

    // a zero TIMEOUT never expires; the counter may then wrap harmlessly
    assign expired = (TIMEOUT != 0) && (tcnt_q == LAST);
    assign busy    = (state_q == DATA);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        op_d    = op_q;
        data_d  = data_q;
        cmd_d   = cmd;
        exec_d  = 1'b0;
        terr_d  = 1'b0;
        if (state_q == IDLE) begin
            if (rx_valid && !rx_data[7]) begin
                cmd_d  = {32'h0, rx_data};
                exec_d = 1'b1;
            end else if (rx_valid) begin
                op_d    = rx_data;
                data_d  = '0;
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = DATA;
            end
        end else if (rx_valid) begin
            // an arriving byte beats a simultaneous expiry
            data_d[{cnt_q, 3'b000} +: 8] = rx_data;
            cnt_d  = cnt_q + 2'd1;
            tcnt_d = '0;
            if (cnt_q == 2'd3) begin
                cmd_d   = {rx_data, data_q[23:0], op_q};
                exec_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (expired) begin
            terr_d  = 1'b1;
            state_d = IDLE;
            op_d    = '0;
            data_d  = '0;
            cnt_d   = '0;
            tcnt_d  = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            op_q        <= '0;
            data_q      <= '0;
            cmd         <= '0;
            execute     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cmd         <= cmd_d;
            execute     <= exec_d;
            timeout_err <= terr_d;
        end
    end
endmodule

// File: tb/tb_sump_cmd_assembler.sv
// tb_sump_cmd_assembler: directed and randomized checks of sump_cmd_assembler against a byte-queue model.
module tb_sump_cmd_assembler;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [39:0] cmd;
    logic        execute, busy, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    bit          m_long;
    logic [7:0]  m_q[$];
    int          m_idle;
    logic [39:0] e_cmd;
    logic        e_exec, e_busy, e_terr;

    always #5 clock = ~clock;

    sump_cmd_assembler #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cmd        (cmd),
        .execute    (execute),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    function automatic void model_reset();
        m_long = 1'b0;
        m_q.delete();
        m_idle = 0;
        e_cmd  = '0;
        e_exec = 1'b0;
        e_busy = 1'b0;
        e_terr = 1'b0;
    endfunction

    // Collect a whole command as a list of bytes; emit it once five bytes are present.
    function automatic void model(bit v, logic [7:0] d);
        e_exec = 1'b0;
        e_terr = 1'b0;
        if (!m_long) begin
            if (v && d[7]) begin
                m_long = 1'b1;
                m_q.delete();
                m_q.push_back(d);
                m_idle = 0;
            end else if (v) begin
                e_cmd  = {32'h0, d};
                e_exec = 1'b1;
            end
        end else if (v) begin
            m_q.push_back(d);
            m_idle = 0;
            if (m_q.size() == 5) begin
                e_cmd  = {m_q[4], m_q[3], m_q[2], m_q[1], m_q[0]};
                e_exec = 1'b1;
                m_long = 1'b0;
                m_q.delete();
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                e_terr = 1'b1;
                m_long = 1'b0;
                m_q.delete();
            end
        end
        e_busy = m_long;
    endfunction

    task automatic check(string tag);
        assert (cmd === e_cmd) else begin
            n_err++; $error("FAIL %s cmd got %h want %h", tag, cmd, e_cmd);
        end
        assert (execute === e_exec) else begin
            n_err++; $error("FAIL %s execute got %b want %b", tag, execute, e_exec);
        end
        assert (busy === e_busy) else begin
            n_err++; $error("FAIL %s busy got %b want %b", tag, busy, e_busy);
        end
        assert (timeout_err === e_terr) else begin
            n_err++; $error("FAIL %s timeout_err got %b want %b", tag, timeout_err, e_terr);
        end
    endtask

    task automatic expect_cmd(string tag, logic [39:0] want, logic want_exec);
        assert (cmd === want && execute === want_exec) else begin
            n_err++; $error("FAIL %s cmd/execute got %h/%b want %h/%b", tag, cmd, execute, want, want_exec);
        end
    endtask

    task automatic step(bit v, logic [7:0] d, string tag);
        rx_valid = v;
        rx_data  = d;
        @(posedge clock);
        model(v, d);
        #1;
        n_vec++;
        check(tag);
    endtask

    task automatic bytes5(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d, logic [7:0] e, string tag);
        step(1'b1, a, tag);
        step(1'b1, b, tag);
        step(1'b1, c, tag);
        step(1'b1, d, tag);
        step(1'b1, e, tag);
    endtask

    initial begin
        model_reset();
        #3;
        n_vec++;
        check("reset_state");
        @(negedge clock);
        reset_n = 1'b1;

        step(1'b1, 8'h02, "short");
        expect_cmd("short_02", 40'h00000000_02, 1'b1);
        step(1'b0, 8'h00, "short_idle");

        bytes5(8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, "long_b2b");
        expect_cmd("long_c0", 40'h44332211_C0, 1'b1);
        step(1'b1, 8'h11, "short_after_long");
        expect_cmd("short_11", 40'h00000000_11, 1'b1);
        step(1'b0, 8'h00, "idle");

        bytes5(8'h82, 8'hFF, 8'h80, 8'h81, 8'h90, "bit7_data");
        expect_cmd("long_82", 40'h908180FF_82, 1'b1);
        step(1'b0, 8'h00, "idle");

        step(1'b1, 8'h82, "to_op");
        step(1'b1, 8'hAA, "to_data");
        for (int i = 0; i < TO; i++) step(1'b0, 8'h00, "to_wait");
        assert (timeout_err === 1'b1 && busy === 1'b0) else begin
            n_err++; $error("FAIL to_pulse timeout_err/busy got %b/%b want 1/0", timeout_err, busy);
        end
        expect_cmd("to_cmd_kept", 40'h908180FF_82, 1'b0);
        step(1'b0, 8'h00, "to_after");
        step(1'b1, 8'h13, "to_resync");
        expect_cmd("short_13", 40'h00000000_13, 1'b1);

        step(1'b1, 8'h82, "col_op");
        step(1'b1, 8'hAA, "col_d0");
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, "col_wait");
        step(1'b1, 8'hBB, "col_hit");
        assert (timeout_err === 1'b0 && busy === 1'b1) else begin
            n_err++; $error("FAIL col_hit timeout_err/busy got %b/%b want 0/1", timeout_err, busy);
        end
        step(1'b1, 8'hCC, "col_d2");
        step(1'b1, 8'hDD, "col_d3");
        expect_cmd("col_done", 40'hDDCCBBAA_82, 1'b1);

        step(1'b1, 8'hC0, "rst_op");
        step(1'b1, 8'h01, "rst_d0");
        rx_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        check("rst_async");
        repeat (3) begin
            @(posedge clock);
            #1;
            n_vec++;
            check("rst_hold");
        end
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 8'h00, "rst_after");
        expect_cmd("rst_zero_cmd", 40'h0, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 8'h00, "sump_reset");

        for (int i = 0; i < 400; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, "rand_gap");
            step(1'b1, 8'($urandom), "rand_byte");
        end
        for (int i = 0; i < TO + 2; i++) step(1'b0, 8'h00, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
